// File: rtl/ysyx_25010008_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit: one shift-add or restoring
// subtract-shift step per cycle, with single-cycle bypass for divide-by-zero/overflow.
module ysyx_25010008_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned AW = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] res_q, res_d;

  // Request decode: sign flags, magnitudes and bypass conditions
  logic            sgn1_c, sgn2_c, div_zero_c, ovf_c;
  logic [XLEN-1:0] mag1_c, mag2_c, special_c;

  always_comb begin
    sgn1_c     = ((opcode == OP_MULH) || (opcode == OP_MULHSU) || (opcode == OP_DIV) ||
                  (opcode == OP_REM)) && operand1[XLEN-1];
    sgn2_c     = ((opcode == OP_MULH) || (opcode == OP_DIV) || (opcode == OP_REM)) &&
                 operand2[XLEN-1];
    mag1_c     = sgn1_c ? -operand1 : operand1;
    mag2_c     = sgn2_c ? -operand2 : operand2;
    div_zero_c = opcode[2] && (operand2 == '0);
    ovf_c      = ((opcode == OP_DIV) || (opcode == OP_REM)) &&
                 (operand1 == MIN_NEG) && (operand2 == '1);
    if (div_zero_c) special_c = opcode[1] ? operand1 : '1;
    else            special_c = opcode[1] ? '0 : operand1;
  end

  // One datapath step: multiply shift-add or restoring divide subtract-shift
  logic [XLEN:0]   mul_sum_c, div_shift_c, div_diff_c;
  logic [AW-1:0]   acc_step_c, prod_c;
  logic [XLEN-1:0] quo_c, rem_c, final_c;

  always_comb begin
    mul_sum_c   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift_c = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    div_diff_c  = div_shift_c - {1'b0, a_q};
    if (!op_q[2]) begin
      acc_step_c = {mul_sum_c, acc_q[XLEN-1:1]};
    end else if (!div_diff_c[XLEN]) begin
      acc_step_c = {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step_c = {div_shift_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    prod_c = neg_q ? -acc_step_c : acc_step_c;
    quo_c  = acc_step_c[XLEN-1:0];
    rem_c  = acc_step_c[AW-1:XLEN];
    if (!op_q[2])      final_c = (op_q == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[AW-1:XLEN];
    else if (!op_q[1]) final_c = neg_q ? -quo_c : quo_c;
    else               final_c = rneg_q ? -rem_c : rem_c;
  end

  // Next-state and datapath update; flush overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d   = opcode;
            neg_d  = sgn1_c ^ sgn2_c;
            rneg_d = sgn1_c;
            if (opcode[2]) begin
              a_d   = mag2_c;
              acc_d = {{XLEN{1'b0}}, mag1_c};
            end else begin
              a_d   = mag1_c;
              acc_d = {{XLEN{1'b0}}, mag2_c};
            end
            if (div_zero_c || ovf_c) begin
              state_d = S_DONE;
              res_d   = special_c;
            end else begin
              state_d = S_CALC;
              cnt_d   = CW'(XLEN);
            end
          end
        end
        S_CALC: begin
          acc_d = acc_step_c;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            res_d   = final_c;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = res_q;

endmodule

// File: tb/tb_ysyx_25010008_muldiv.sv
// Table-driven scoreboard bench for ysyx_25010008_muldiv (XLEN = 32).
module tb_ysyx_25010008_muldiv;

  logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  opcode;
  logic [31:0] operand1, operand2, result;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  ysyx_25010008_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand1(operand1), .operand2(operand2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a request at a negedge; it is accepted at the following posedge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; operand1 = a; operand2 = b;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0; opcode = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for out_valid (counted in cycles since accept), check, then consume
  task automatic drain(input int exp_lat);
    int lat;
    logic [31:0] exp;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    chk("result", result, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_handshake", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic no_valid_for(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    tbl[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tbl[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tbl[12] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    tbl[13] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
    tbl[14] = '{3'd1, 32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF, 33};
    tbl[15] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    opcode = '0; operand1 = '0; operand2 = '0;
    #1;
    chk("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    chk("reset_result", result, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
      drain(tbl[i].lat);
    end

    // Backpressure: DONE held 5 cycles while a new request waits
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    begin
      int lat;
      lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      chk("bp_latency", 32'(lat), 32'd33);
    end
    in_valid = 1'b1; opcode = 3'd0; operand1 = 32'd5; operand2 = 32'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_result", result, 32'd14);
      chk("bp_hold_flags", {30'd0, out_valid, in_ready}, 32'd2);
    end
    chk("bp_result", result, sb.size() > 0 ? sb.pop_front() : 32'hDEAD_BEEF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(32'd30);
    @(negedge clk);
    in_valid = 1'b0;
    drain(33);

    // Flush in CALC
    issue(3'd3, 32'd9, 32'd9, 32'd0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_calc_idle", {30'd0, in_ready, busy}, 32'd2);
    void'(sb.pop_front());
    no_valid_for("flush_calc_no_valid", 40);
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    drain(33);

    // Flush in DONE with out_ready also high
    issue(3'd5, 32'd5, 32'd0, 32'd0);
    chk("flush_done_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_idle", {30'd0, out_valid, in_ready}, 32'd1);
    void'(sb.pop_front());
    no_valid_for("flush_done_no_valid", 5);
    issue(3'd7, 32'd100, 32'd7, 32'd2);
    drain(33);

    // Asynchronous reset mid-CALC, request presented with the release
    issue(3'd0, 32'd11, 32'd13, 32'd0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {29'd0, in_ready, out_valid, busy}, 32'h4);
    chk("async_reset_result", result, 32'd0);
    void'(sb.pop_front());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; opcode = 3'd0; operand1 = 32'd3; operand2 = 32'd4;
    @(posedge clk);
    sb.push_back(32'd12);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_reset_accept", 32'(busy), 32'd1);
    drain(33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

endmodule
